vegeta_pu_ctrl: RTL and testbench
=================================

VEGETA_PU_CTRL -- requirements
Module: vegeta_pu_ctrl

Interface
REQ-001 The block SHALL take these parameters:
- N_ROWS, default 16: weight beats per tile load.
- TILE_W, default 8: width of the tile count.
- LEN_W, default 8: width of the activation length.
- DRAIN_CYC, default 20: cycles to flush the PE array after the last activation.
REQ-002 The block SHALL have a single clock, clk. Reset rst is synchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_mode  in  2  PU mode for the job
- cmd_gemm_mode  in  2  dense / 2:4 / 1:4 select
- cmd_num_tiles  in  TILE_W  weight tiles in the job
- cmd_act_len  in  LEN_W  activation beats per tile
- w_valid  in  1  weight beat available
- w_ready  out  1  weight beat accepted
- a_valid  in  1  activation beat available
- a_ready  out  1  activation beat accepted
- pu_weight_transferring  out  1  weight shift-in strobe to the PU array
- pu_i_wb  out  1  weight buffer currently being loaded
- pu_act_en  out  1  activation beat presented to the array
- pu_mode  out  2  latched mode
- pu_gemm_mode  out  2  latched gemm mode
- tile_idx  out  TILE_W  index of the tile being computed
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, COMPUTE, DRAIN and DONE.
REQ-005 cmd_ready SHALL be 1 only in IDLE. A command is accepted when cmd_valid and cmd_ready are both 1 on a rising edge.
REQ-006 On acceptance, the block SHALL:
- latch mode, gemm_mode, num_tiles and act_len (act_len 0 is treated as 1);
- clear tile_idx and both beat counters;
- go to LOAD.
REQ-007 If accepted num_tiles is 0, the block SHALL go directly to DONE without loading or computing.
REQ-008 In LOAD:
- w_ready SHALL be 1.
- Each handshake w_valid&w_ready SHALL assert pu_weight_transferring in that same cycle and increment the load counter.
- When the N_ROWS-th beat is accepted, the block SHALL toggle the active buffer and go to COMPUTE the next cycle.
REQ-009 pu_i_wb SHALL indicate the buffer being loaded. The array computes from !pu_i_wb.
REQ-010 In COMPUTE:
- a_ready SHALL be 1.
- pu_act_en SHALL equal a_valid&a_ready.
- Each accepted activation beat SHALL increment the activation counter.
REQ-011 Preload during COMPUTE:
- If tile_idx+1 < num_tiles, w_ready SHALL be 1 and accepted beats SHALL load the inactive buffer (pu_i_wb) with pu_weight_transferring asserted.
- Preload stops once N_ROWS beats have been accepted.
- Otherwise w_ready SHALL be 0.
REQ-012 On acceptance of the act_len-th activation beat:
- If it is the last tile, the block SHALL go to DRAIN.
- Else, if preload is complete, the block SHALL toggle the buffer, increment tile_idx, clear both counters and stay in COMPUTE.
- Else, the block SHALL increment tile_idx and go to LOAD, keeping the partial preload count so the load resumes at that count.
REQ-013 A weight beat and the final activation beat completing in the same cycle SHALL count as preload complete.
REQ-014 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to DONE.
REQ-015 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 w_ready and a_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-018 pu_mode and pu_gemm_mode SHALL hold their latched values until the next accepted command.
REQ-019 Counters SHALL never exceed N_ROWS or act_len. No input beat is accepted beyond those limits.
REQ-020 Stalls (w_valid=0 or a_valid=0) SHALL freeze the corresponding counter. No timeout is required.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL:
- go to IDLE;
- clear all counters, tile_idx, pu_i_wb, pu_mode, pu_gemm_mode and done.
REQ-022 Outputs after reset SHALL be: cmd_ready=1; every other output 0.
REQ-023 Reset asserted mid-job, in any state, SHALL abort the job within that edge. No done pulse SHALL be generated.

Verification
REQ-024 Single tile, num_tiles=1, act_len=4, N_ROWS=16, all valids held high:
- 16 cycles with pu_weight_transferring=1;
- then 4 cycles with pu_act_en=1;
- then 20 drain cycles;
- then done=1 for one cycle;
- pu_i_wb=1 during COMPUTE.
REQ-025 Three tiles, act_len=32, w_valid always 1: preload completes inside COMPUTE, giving back-to-back COMPUTE with tile_idx 0,1,2, pu_i_wb toggling at each tile boundary, and no LOAD re-entry.
REQ-026 Two tiles, act_len=4 (shorter than N_ROWS): COMPUTE ends with preload count 4, LOAD re-entered, and exactly 12 further weight beats accepted before the second COMPUTE.
REQ-027 num_tiles=0 command: DONE on the cycle after acceptance; zero weight and zero activation beats.
REQ-028 Random w_valid/a_valid gaps (50%): total accepted weight beats = 16×num_tiles and activation beats = act_len×num_tiles; pu_act_en never asserted outside COMPUTE.
REQ-029 rst pulsed during COMPUTE of tile 1: next cycle in IDLE with cmd_ready=1 and all other outputs 0; a new command after reset runs normally from tile_idx=0.

Source files
------------

// File: rtl/vegeta_pu_ctrl.sv
// Job controller for the VEGETA PU array: loads weight tiles into a double
// buffer, streams activations per tile, overlaps the next tile's load with compute.
module vegeta_pu_ctrl #(
  parameter int N_ROWS    = 16,
  parameter int TILE_W    = 8,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [1:0]        cmd_gemm_mode,
  input  logic [TILE_W-1:0] cmd_num_tiles,
  input  logic [LEN_W-1:0]  cmd_act_len,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              a_valid,
  output logic              a_ready,
  output logic              pu_weight_transferring,
  output logic              pu_i_wb,
  output logic              pu_act_en,
  output logic [1:0]        pu_mode,
  output logic [1:0]        pu_gemm_mode,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = $clog2(N_ROWS + 1);
  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [WC_W-1:0] ROWS      = WC_W'(N_ROWS);
  localparam logic [DC_W-1:0] DRAIN_END = DC_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WC_W-1:0]   w_cnt;
  logic [LEN_W-1:0]  a_cnt;
  logic [TILE_W-1:0] num_tiles_q;
  logic [LEN_W-1:0]  act_len_q;
  logic [DC_W-1:0]   drain_cnt;
  logic              wb;

  logic has_next, preload_full, w_fire, a_fire, w_row_last, a_last;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and valid may be dropped at any time.
  assign has_next     = ({1'b0, tile_idx} + {{TILE_W{1'b0}}, 1'b1}) < {1'b0, num_tiles_q};
  assign preload_full = (w_cnt == ROWS);

  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    case (state)
      S_LOAD:    w_ready = 1'b1;
      S_COMPUTE: begin
        a_ready = 1'b1;
        w_ready = has_next && !preload_full;
      end
      default: ;
    endcase
  end

  assign w_fire     = w_valid && w_ready;
  assign a_fire     = a_valid && a_ready;
  assign w_row_last = w_fire && (w_cnt == ROWS - WC_W'(1));
  assign a_last     = a_fire && (a_cnt == act_len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (cmd_valid) state_nxt = (cmd_num_tiles == '0) ? S_DONE : S_LOAD;
      S_LOAD:
        if (w_row_last) state_nxt = S_COMPUTE;
      S_COMPUTE:
        if (a_last) begin
          if (!has_next)                       state_nxt = S_DRAIN;
          else if (preload_full || w_row_last) state_nxt = S_COMPUTE;
          else                                 state_nxt = S_LOAD;
        end
      S_DRAIN:
        if (drain_cnt == DRAIN_END) state_nxt = S_DONE;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt        <= '0;
      a_cnt        <= '0;
      tile_idx     <= '0;
      num_tiles_q  <= '0;
      act_len_q    <= '0;
      drain_cnt    <= '0;
      wb           <= 1'b0;
      pu_mode      <= '0;
      pu_gemm_mode <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            pu_mode      <= cmd_mode;
            pu_gemm_mode <= cmd_gemm_mode;
            num_tiles_q  <= cmd_num_tiles;
            act_len_q    <= (cmd_act_len == '0) ? LEN_W'(1) : cmd_act_len;
            tile_idx     <= '0;
            w_cnt        <= '0;
            a_cnt        <= '0;
          end
        S_LOAD:
          if (w_row_last) begin
            w_cnt <= '0;
            wb    <= ~wb;
          end else if (w_fire) begin
            w_cnt <= w_cnt + WC_W'(1);
          end
        S_COMPUTE: begin
          drain_cnt <= '0;
          if (a_last) begin
            a_cnt <= '0;
            if (has_next) begin
              tile_idx <= tile_idx + TILE_W'(1);
              // A complete preload swaps buffers; a partial one is resumed in LOAD.
              if (preload_full || w_row_last) begin
                wb    <= ~wb;
                w_cnt <= '0;
              end else if (w_fire) begin
                w_cnt <= w_cnt + WC_W'(1);
              end
            end
          end else begin
            if (a_fire) a_cnt <= a_cnt + LEN_W'(1);
            if (w_fire) w_cnt <= w_cnt + WC_W'(1);
          end
        end
        S_DRAIN:
          drain_cnt <= drain_cnt + DC_W'(1);
        default: ;
      endcase
    end
  end

  assign cmd_ready              = (state == S_IDLE);
  assign busy                   = (state != S_IDLE);
  assign done                   = (state == S_DONE);
  assign pu_weight_transferring = w_fire;
  assign pu_act_en              = a_fire;
  assign pu_i_wb                = wb;

endmodule

// File: tb/tb_vegeta_pu_ctrl.sv
// Randomized bench for vegeta_pu_ctrl: a transaction-level model tracks beats per
// tile, buffer ownership and job latency, and checks every cycle.
module tb_vegeta_pu_ctrl;

  localparam int N_ROWS    = 16;
  localparam int TILE_W    = 8;
  localparam int LEN_W     = 8;
  localparam int DRAIN_CYC = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = '0;
  logic [1:0]        cmd_gemm_mode = '0;
  logic [TILE_W-1:0] cmd_num_tiles = '0;
  logic [LEN_W-1:0]  cmd_act_len = '0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic              pu_weight_transferring;
  logic              pu_i_wb;
  logic              pu_act_en;
  logic [1:0]        pu_mode;
  logic [1:0]        pu_gemm_mode;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              done;

  vegeta_pu_ctrl #(
    .N_ROWS(N_ROWS), .TILE_W(TILE_W), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_gemm_mode(cmd_gemm_mode),
    .cmd_num_tiles(cmd_num_tiles), .cmd_act_len(cmd_act_len),
    .w_valid(w_valid), .w_ready(w_ready),
    .a_valid(a_valid), .a_ready(a_ready),
    .pu_weight_transferring(pu_weight_transferring), .pu_i_wb(pu_i_wb),
    .pu_act_en(pu_act_en), .pu_mode(pu_mode), .pu_gemm_mode(pu_gemm_mode),
    .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model state
  bit                job_active = 1'b0;
  bit                full_rate  = 1'b1;
  int                job_t, job_l, accept_cyc, last_act_cyc;
  int                w_total, a_total;
  int                jobs_done = 0;
  logic [1:0]        exp_mode = '0;
  logic [1:0]        exp_gemm = '0;
  logic              wbuf [0:255];
  logic [TILE_W-1:0] exp_q [$];

  function automatic int exp_latency(input int t, input int l);
    if (t == 0) return 1;
    return N_ROWS + t * l + (t - 1) * ((l < N_ROWS) ? N_ROWS - l : 0) + DRAIN_CYC + 1;
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      job_active = 1'b0;
      exp_mode   = '0;
      exp_gemm   = '0;
      exp_q.delete();
    end else begin
      chk("busy", int'(busy), int'(job_active));
      chk("cmd_ready", int'(cmd_ready), int'(!job_active));
      chk("pu_mode", int'(pu_mode), int'(exp_mode));
      chk("pu_gemm_mode", int'(pu_gemm_mode), int'(exp_gemm));
      chk("act_en", int'(pu_act_en), int'(a_valid && a_ready));
      chk("w_strobe", int'(pu_weight_transferring), int'(w_valid && w_ready));
      if (!job_active)
        chk("idle_quiet", int'({w_ready, a_ready, done, pu_act_en, pu_weight_transferring}), 0);

      if (a_valid && a_ready && job_active) begin
        automatic int t = a_total / job_l;
        chk("a_in_job", int'(a_total < job_l * job_t), 1);
        chk("weights_before_act", int'(w_total >= N_ROWS * (t + 1)), 1);
        if (t < 256) chk("compute_buf", int'(!pu_i_wb), int'(wbuf[t]));
        chk("act_q_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("tile_idx", int'(tile_idx), int'(exp_q.pop_front()));
        a_total++;
        last_act_cyc = cyc;
      end

      if (w_valid && w_ready && job_active) begin
        automatic int wt = w_total / N_ROWS;
        automatic int at = a_total / job_l;
        chk("w_in_job", int'(w_total < N_ROWS * job_t), 1);
        chk("preload_ahead", int'(wt <= at + 1), 1);
        if (wt < 256) begin
          if (w_total % N_ROWS == 0) begin
            if (wt > 0) chk("buf_swap", int'(pu_i_wb != wbuf[wt-1]), 1);
            wbuf[wt] = pu_i_wb;
          end else begin
            chk("buf_steady", int'(pu_i_wb), int'(wbuf[wt]));
          end
        end
        w_total++;
      end

      if (done && job_active) begin
        chk("w_total", w_total, N_ROWS * job_t);
        chk("a_total", a_total, job_l * job_t);
        chk("q_empty", exp_q.size(), 0);
        if (job_t > 0) chk("drain_len", cyc - last_act_cyc, DRAIN_CYC + 1);
        if (full_rate) chk("latency", cyc - accept_cyc, exp_latency(job_t, job_l));
        job_active = 1'b0;
        jobs_done++;
      end

      if (cmd_valid && cmd_ready) begin
        job_t      = int'(cmd_num_tiles);
        job_l      = (cmd_act_len == '0) ? 1 : int'(cmd_act_len);
        accept_cyc = cyc;
        w_total    = 0;
        a_total    = 0;
        exp_mode   = cmd_mode;
        exp_gemm   = cmd_gemm_mode;
        exp_q.delete();
        for (int t = 0; t < job_t; t++)
          for (int b = 0; b < job_l; b++) exp_q.push_back(TILE_W'(t));
        job_active = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (full_rate) begin
      w_valid = 1'b1;
      a_valid = 1'b1;
    end else begin
      w_valid = 1'($urandom_range(0, 1));
      a_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic issue_cmd(input int t, input int l, input bit fr);
    int n;
    full_rate = fr;
    tick();
    cmd_mode      = 2'($urandom_range(0, 3));
    cmd_gemm_mode = 2'($urandom_range(0, 3));
    cmd_num_tiles = TILE_W'(t);
    cmd_act_len   = LEN_W'(l);
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_job(input int t, input int l, input bit fr);
    int start, n;
    start = jobs_done;
    issue_cmd(t, l, fr);
    n = 0;
    while (jobs_done == start && n < 5000) begin
      tick();
      n++;
    end
    chk("job_completed", jobs_done - start, 1);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_outputs", int'({busy, done, w_ready, a_ready, pu_i_wb, pu_act_en,
                             pu_weight_transferring, pu_mode, pu_gemm_mode, tile_idx}), 0);

    // directed full-rate jobs: single tile, back-to-back, short act_len, zero tiles,
    // act_len 0, act_len equal to N_ROWS
    run_job(1, 4, 1'b1);
    run_job(3, 32, 1'b1);
    run_job(2, 4, 1'b1);
    run_job(0, 5, 1'b1);
    run_job(2, 0, 1'b1);
    run_job(2, 16, 1'b1);
    run_job(1, 255, 1'b1);

    // random gaps on both streams
    for (int j = 0; j < 20; j++)
      run_job($urandom_range(0, 4), $urandom_range(0, 40), 1'b0);

    // abort in the middle of tile 1
    issue_cmd(3, 8, 1'b1);
    n = 0;
    while (!(tile_idx == TILE_W'(1) && a_ready) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_tile1", int'(tile_idx), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_outputs", int'({busy, done, w_ready, a_ready, pu_i_wb, pu_act_en,
                               pu_weight_transferring, pu_mode, pu_gemm_mode, tile_idx}), 0);
    repeat (30) tick();
    run_job(2, 6, 1'b1);
    run_job(3, 12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
